inst_fetch_seq: RTL

- Sequencer between the synchronous instruction ROM and the processor datapath/control FSM.
- Replaces the manual address-counter stepping: issues ROM addresses, waits out ROM read latency, registers the word onto DIN, pulses run, then waits for done before advancing.
- Supports free-run and single-step modes, an instruction counter, and a done-timeout watchdog.

---
 rtl/inst_fetch_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: steps the ROM address, waits out read latency,
// registers the word onto DIN, pulses run and waits for done before advancing.
module inst_fetch_seq #(
  parameter int DW        = 16,
  parameter int AW        = 5,
  parameter int MEM_LAT   = 1,
  parameter int LAST_ADDR = 31,
  parameter int WRAP      = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          step_mode,
  input  logic [DW-1:0] mem_q,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] DIN,
  output logic          run,
  input  logic          done,
  input  logic          next_word,
  output logic          busy,
  output logic          halted,
  output logic          timeout_err,
  output logic [15:0]   instr_count
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);
  localparam bit NO_WRAP = (WRAP == 0);

  typedef enum logic [2:0] {
    IDLE, ADDR, CAPTURE, RUN, WAIT_DONE, HALT
  } state_t;

  state_t           state_reg;
  logic [AW-1:0]    addr_reg;
  logic [DW-1:0]    din_reg;
  logic             run_reg;
  logic             busy_reg;
  logic             halted_reg;
  logic             tout_reg;
  logic [15:0]      count_reg;
  logic [2:0]       lat_cnt_reg;
  logic [WDW-1:0]   wd_cnt_reg;
  logic             stop_lat_reg;
  logic             imm_fetch_reg;

  logic [AW-1:0]    addr_inc;
  logic             at_end;

  assign addr_inc = (addr_reg == LAST) ? '0 : addr_reg + AW'(1);
  assign at_end   = NO_WRAP && (addr_reg == LAST);

  assign mem_addr    = addr_reg;
  assign DIN         = din_reg;
  assign run         = run_reg;
  assign busy        = busy_reg;
  assign halted      = halted_reg;
  assign timeout_err = tout_reg;
  assign instr_count = count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      din_reg       <= '0;
      run_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      halted_reg    <= 1'b0;
      tout_reg      <= 1'b0;
      count_reg     <= '0;
      lat_cnt_reg   <= '0;
      wd_cnt_reg    <= '0;
      stop_lat_reg  <= 1'b0;
      imm_fetch_reg <= 1'b0;
    end else begin
      run_reg <= 1'b0;
      // Halt entries below override this, so a stop is consumed by HALT.
      if (busy_reg && stop) stop_lat_reg <= 1'b1;

      case (state_reg)
        IDLE, HALT: begin
          if (start) begin
            state_reg   <= ADDR;
            lat_cnt_reg <= '0;
            busy_reg    <= 1'b1;
            halted_reg  <= 1'b0;
          end
        end

        ADDR: begin
          if (lat_cnt_reg == 3'(MEM_LAT - 1)) begin
            lat_cnt_reg <= '0;
            state_reg   <= CAPTURE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 3'd1;
          end
        end

        CAPTURE: begin
          din_reg   <= mem_q;
          run_reg   <= 1'b1;
          state_reg <= RUN;
        end

        RUN: begin
          wd_cnt_reg    <= '0;
          imm_fetch_reg <= 1'b0;
          state_reg     <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (done) begin
            imm_fetch_reg <= 1'b0;
            if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
            if (stop_lat_reg || stop || step_mode || at_end) begin
              if (!at_end) addr_reg <= addr_inc;
              state_reg    <= HALT;
              busy_reg     <= 1'b0;
              halted_reg   <= 1'b1;
              stop_lat_reg <= 1'b0;
            end else begin
              addr_reg    <= addr_inc;
              lat_cnt_reg <= '0;
              state_reg   <= ADDR;
            end
          end else if (wd_cnt_reg == WDW'(TIMEOUT - 1)) begin
            tout_reg      <= 1'b1;
            imm_fetch_reg <= 1'b0;
            state_reg     <= HALT;
            busy_reg      <= 1'b0;
            halted_reg    <= 1'b1;
            stop_lat_reg  <= 1'b0;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + WDW'(1);
            // Immediate fetch: one extra cycle beyond MEM_LAT for the address to reach the ROM.
            if (imm_fetch_reg) begin
              if (lat_cnt_reg == 3'(MEM_LAT)) begin
                din_reg       <= mem_q;
                imm_fetch_reg <= 1'b0;
              end else begin
                lat_cnt_reg <= lat_cnt_reg + 3'd1;
              end
            end else if (next_word) begin
              addr_reg      <= addr_inc;
              imm_fetch_reg <= 1'b1;
              lat_cnt_reg   <= '0;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
